// File: rtl/tx_state_if.sv
// tx_state_if: handshake and line signals between a UART transmit
// controller (slave side) and the logic that feeds it (master side).
interface tx_state_if #(
  parameter int INPUT_DATA_WIDTH = 8
);
  logic                        baud_tick;
  logic                        tx_start;
  logic [INPUT_DATA_WIDTH-1:0] i_data;
  logic                        serial_out;
  logic                        tx_busy;
  logic                        tx_done;
  logic [3:0]                  state;

  modport master (
    output baud_tick,
    output tx_start,
    output i_data,
    input  serial_out,
    input  tx_busy,
    input  tx_done,
    input  state
  );

  modport slave (
    input  baud_tick,
    input  tx_start,
    input  i_data,
    output serial_out,
    output tx_busy,
    output tx_done,
    output state
  );
endinterface

// File: rtl/tx_state.sv
// tx_state: UART transmit sequencer. A request is captured in IDLE and the
// frame starts on the next baud_tick, so every bit lasts one full baud
// period. serial_out is registered and changes on the same edge as state.
//
// Optional feature macro: TX_PARITY_EN
//   defined   -> 11-bit frame: start, 8 data (LSB first), even parity, stop
//   undefined -> 10-bit frame: start, 8 data, stop; parity logic absent
//
// state      | meaning
// IDLE       | line high; accept request, wait for tick if pending
// START_BIT  | line low for one baud period
// DATA_BIT_n | line carries captured data bit n
// PARITY_BIT | line carries even parity of the captured data
// STOP_BIT   | line high; next tick ends the frame and pulses tx_done
module tx_state #(
  parameter int INPUT_DATA_WIDTH = 8
) (
  input  logic    clk,
  input  logic    reset,
  tx_state_if.slave bus
);

  typedef enum logic [3:0] {
    IDLE       = 4'd0,
    START_BIT  = 4'd1,
    DATA_BIT_0 = 4'd2,
    DATA_BIT_1 = 4'd3,
    DATA_BIT_2 = 4'd4,
    DATA_BIT_3 = 4'd5,
    DATA_BIT_4 = 4'd6,
    DATA_BIT_5 = 4'd7,
    DATA_BIT_6 = 4'd8,
    DATA_BIT_7 = 4'd9,
    PARITY_BIT = 4'd10,
    STOP_BIT   = 4'd11
  } state_e;

  state_e                      state_q, state_d;
  logic                        serial_out_q, serial_out_d;
  logic                        tx_busy_q, tx_busy_d;
  logic                        tx_done_q, tx_done_d;
  logic                        pending_q, pending_d;
  logic [INPUT_DATA_WIDTH-1:0] shift_q, shift_d;
`ifdef TX_PARITY_EN
  logic                        parity_q, parity_d;
`endif

  logic accept;

  // Next-state, line value and request bookkeeping.
  always_comb begin
    state_d      = state_q;
    serial_out_d = serial_out_q;
    tx_busy_d    = tx_busy_q;
    tx_done_d    = 1'b0;
    pending_d    = pending_q;
    shift_d      = shift_q;
`ifdef TX_PARITY_EN
    parity_d     = parity_q;
`endif

    // pending_q is still low on the acceptance edge, so a coincident
    // baud_tick cannot start the frame early.
    accept = (state_q == IDLE) && !pending_q && bus.tx_start;
    if (accept) begin
      shift_d   = bus.i_data;
      pending_d = 1'b1;
      tx_busy_d = 1'b1;
`ifdef TX_PARITY_EN
      parity_d  = ^bus.i_data;
`endif
    end

    if (bus.baud_tick) begin
      case (state_q)
        IDLE: begin
          if (pending_q) begin
            state_d      = START_BIT;
            serial_out_d = 1'b0;
          end
        end
        START_BIT: begin
          state_d      = DATA_BIT_0;
          serial_out_d = shift_q[0];
          shift_d      = shift_q >> 1;
        end
        DATA_BIT_0, DATA_BIT_1, DATA_BIT_2, DATA_BIT_3,
        DATA_BIT_4, DATA_BIT_5, DATA_BIT_6: begin
          state_d      = state_e'(state_q + 4'd1);
          serial_out_d = shift_q[0];
          shift_d      = shift_q >> 1;
        end
        DATA_BIT_7: begin
`ifdef TX_PARITY_EN
          state_d      = PARITY_BIT;
          serial_out_d = parity_q;
`else
          state_d      = STOP_BIT;
          serial_out_d = 1'b1;
`endif
        end
`ifdef TX_PARITY_EN
        PARITY_BIT: begin
          state_d      = STOP_BIT;
          serial_out_d = 1'b1;
        end
`endif
        STOP_BIT: begin
          state_d      = IDLE;
          serial_out_d = 1'b1;
          tx_busy_d    = 1'b0;
          pending_d    = 1'b0;
          tx_done_d    = 1'b1;
        end
        default: begin
          state_d      = IDLE;
          serial_out_d = 1'b1;
        end
      endcase
    end
  end

  // State and output registers; reset forces an idle line immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      serial_out_q <= 1'b1;
      tx_busy_q    <= 1'b0;
      tx_done_q    <= 1'b0;
      pending_q    <= 1'b0;
      shift_q      <= '0;
`ifdef TX_PARITY_EN
      parity_q     <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      serial_out_q <= serial_out_d;
      tx_busy_q    <= tx_busy_d;
      tx_done_q    <= tx_done_d;
      pending_q    <= pending_d;
      shift_q      <= shift_d;
`ifdef TX_PARITY_EN
      parity_q     <= parity_d;
`endif
    end
  end

  assign bus.serial_out = serial_out_q;
  assign bus.tx_busy    = tx_busy_q;
  assign bus.tx_done    = tx_done_q;
  assign bus.state      = state_q;

endmodule

// File: tb/tb_tx_state.sv
// tb_tx_state: directed checks of the UART transmit sequencer. Frame
// patterns are written in transmission order (start bit leftmost).
module tb_tx_state;

  logic clk = 1'b0;
  logic reset = 1'b0;

  always #5 clk = ~clk;

  tx_state_if #(.INPUT_DATA_WIDTH(8)) bus ();

  tx_state #(.INPUT_DATA_WIDTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int n_cmp = 0;
  int n_err = 0;

`ifdef TX_PARITY_EN
  localparam int         NB     = 11;
  localparam logic [10:0] PAT_A5 = 11'b0_10100101_0_1;
  localparam logic [10:0] PAT_01 = 11'b0_10000000_1_1;
  localparam logic [10:0] PAT_FF = 11'b0_11111111_0_1;
`else
  localparam int         NB     = 10;
  localparam logic [10:0] PAT_A5 = 11'b0_10100101_1_0;
  localparam logic [10:0] PAT_01 = 11'b0_10000000_1_0;
  localparam logic [10:0] PAT_FF = 11'b0_11111111_1_0;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: inputs applied just after an edge, outputs sampled 1ns after the next.
  task automatic step(input logic bt, input logic st);
    bus.baud_tick = bt;
    bus.tx_start  = st;
    @(posedge clk);
    #1;
  endtask

  function automatic int exp_state(input int k);
    if (k == 0)      return 1;
    if (k <= 8)      return k + 1;
    if (k == NB - 1) return 11;
    return 10;
  endfunction

  task automatic frame(input string name, input logic [7:0] d, input logic [10:0] pat,
                       input logic acc_tick, input logic hold, input logic [7:0] mid);
    bus.i_data = d;
    step(acc_tick, 1'b1);
    check({name, "_acc_busy"},  32'(bus.tx_busy), 32'd1);
    check({name, "_acc_state"}, 32'(bus.state), 32'd0);
    check({name, "_acc_line"},  32'(bus.serial_out), 32'd1);
    step(1'b0, hold);
    check({name, "_wait_state"}, 32'(bus.state), 32'd0);
    step(1'b0, hold);
    for (int k = 0; k < NB; k++) begin
      step(1'b1, hold);
      check($sformatf("%s_bit%0d_line", name, k), 32'(bus.serial_out), 32'(pat[10-k]));
      check($sformatf("%s_bit%0d_state", name, k), 32'(bus.state), 32'(exp_state(k)));
      check($sformatf("%s_bit%0d_done", name, k), 32'(bus.tx_done), 32'd0);
      if (k == 2) bus.i_data = mid;
      step(1'b0, hold);
      step(1'b0, hold);
      check($sformatf("%s_bit%0d_hold_line", name, k), 32'(bus.serial_out), 32'(pat[10-k]));
      check($sformatf("%s_bit%0d_hold_state", name, k), 32'(bus.state), 32'(exp_state(k)));
    end
    step(1'b1, hold);
    check({name, "_end_state"}, 32'(bus.state), 32'd0);
    check({name, "_end_line"},  32'(bus.serial_out), 32'd1);
    check({name, "_end_done"},  32'(bus.tx_done), 32'd1);
    check({name, "_end_busy"},  32'(bus.tx_busy), 32'd0);
    step(1'b0, hold);
    check({name, "_post_done"}, 32'(bus.tx_done), 32'd0);
    check({name, "_post_busy"}, 32'(bus.tx_busy), 32'(hold));
  endtask

  initial begin
    bus.baud_tick = 1'b0;
    bus.tx_start  = 1'b0;
    bus.i_data    = 8'h00;

    repeat (2) @(posedge clk);
    #1;
    check("rst_state", 32'(bus.state), 32'd0);
    check("rst_line",  32'(bus.serial_out), 32'd1);
    check("rst_busy",  32'(bus.tx_busy), 32'd0);
    check("rst_done",  32'(bus.tx_done), 32'd0);

    reset = 1'b1;
    step(1'b1, 1'b0);
    check("idle_tick_state", 32'(bus.state), 32'd0);
    check("idle_tick_busy",  32'(bus.tx_busy), 32'd0);

    frame("a5",       8'hA5, PAT_A5, 1'b0, 1'b0, 8'hA5);
    frame("x01",      8'h01, PAT_01, 1'b0, 1'b0, 8'h01);
    frame("xff",      8'hFF, PAT_FF, 1'b0, 1'b0, 8'hFF);
    frame("acc_tick", 8'hA5, PAT_A5, 1'b1, 1'b0, 8'hA5);
    frame("hold",     8'hA5, PAT_A5, 1'b0, 1'b1, 8'h00);

    // Second frame was accepted right after the held one ended (data 0x00).
    step(1'b1, 1'b0);
    check("f2_start_state", 32'(bus.state), 32'd1);
    check("f2_start_line",  32'(bus.serial_out), 32'd0);
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 1'b0);
      check($sformatf("f2_d%0d_line", k), 32'(bus.serial_out), 32'd0);
    end
    check("f2_d3_state", 32'(bus.state), 32'd5);

    #2 reset = 1'b0;
    #1;
    check("mid_rst_line",  32'(bus.serial_out), 32'd1);
    check("mid_rst_state", 32'(bus.state), 32'd0);
    check("mid_rst_busy",  32'(bus.tx_busy), 32'd0);
    check("mid_rst_done",  32'(bus.tx_done), 32'd0);
    step(1'b1, 1'b0);
    check("in_rst_state", 32'(bus.state), 32'd0);
    reset = 1'b1;
    for (int k = 0; k < 13; k++) begin
      step(1'b1, 1'b0);
      check($sformatf("after_rst%0d_done", k),  32'(bus.tx_done), 32'd0);
      check($sformatf("after_rst%0d_state", k), 32'(bus.state), 32'd0);
      check($sformatf("after_rst%0d_busy", k),  32'(bus.tx_busy), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/tx_state.md
TX_STATE -- requirements
Module: tx_state

Interface
REQ-001 SHALL have parameter INPUT_DATA_WIDTH, default 8, number of data bits per frame.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port baud_tick  input  1  one-clk strobe marking each bit-period boundary.
REQ-005 SHALL have port tx_start  input  1  request to send; sampled every clk.
REQ-006 SHALL have port i_data  input  INPUT_DATA_WIDTH  frame payload; captured on acceptance.
REQ-007 SHALL have port serial_out  output  1  registered UART line; idle high.
REQ-008 SHALL have port tx_busy  output  1  high from acceptance until frame end.
REQ-009 SHALL have port tx_done  output  1  one-clk pulse at frame end.
REQ-010 SHALL have port state  output  4  current FSM state encoding.

Function
REQ-011 SHALL encode states IDLE=0, START_BIT=1, DATA_BIT_0..DATA_BIT_7=2..9, PARITY_BIT=10, STOP_BIT=11; no other value is reachable.
REQ-012 SHALL accept tx_start only when state==IDLE and no request is pending; accepting captures i_data into a shift register, computes even parity (XOR of all data bits), sets a pending flag, and sets tx_busy on the same edge.
REQ-013 SHALL ignore tx_start when not accepted; later i_data changes do not affect the frame in flight.
REQ-014 SHALL leave IDLE for START_BIT only on the first baud_tick strictly after the acceptance edge, so every bit lasts one full baud period; a baud_tick in the acceptance cycle does not start the frame.
REQ-015 SHALL advance exactly one state per baud_tick: START_BIT->DATA_BIT_0->...->DATA_BIT_7->PARITY_BIT->STOP_BIT->IDLE; without baud_tick the state holds.
REQ-016 SHALL update serial_out on the same edge as state: IDLE 1, START_BIT 0, DATA_BIT_n data bit n (LSB first), PARITY_BIT parity, STOP_BIT 1.
REQ-017 SHALL, on baud_tick in STOP_BIT, enter IDLE, clear tx_busy and pending, and pulse tx_done high for exactly that one following cycle.
REQ-018 SHALL accept a new tx_start in the first cycle after the return to IDLE; tx_start coincident with the STOP_BIT-ending baud_tick is ignored.
REQ-019 SHALL keep tx_done low in all other cycles and tx_busy low only in IDLE with nothing pending.

Reset
REQ-020 SHALL, on reset low, immediately and asynchronously force state=IDLE, serial_out=1, tx_busy=0, tx_done=0, pending=0, shift register and parity=0.
REQ-021 SHALL abort any frame in progress on reset mid-operation; after reset deasserts, operation resumes from IDLE with no residual request.

Configuration
REQ-022 SHALL honour macro TX_PARITY_EN: defined -> PARITY_BIT state transmitted, 11-bit frame (start, 8 data, parity, stop); undefined -> DATA_BIT_7 goes directly to STOP_BIT, PARITY_BIT unreachable, parity logic removed, 10-bit frame.

Verification
REQ-023 SHALL cover: TX_PARITY_EN defined, tx_start with i_data=0xA5 -> after the next baud_tick, serial_out per tick = 0,1,0,1,0,0,1,0,1,0(parity),1(stop), then tx_done pulses once, tx_busy falls.
REQ-024 SHALL cover: TX_PARITY_EN defined, i_data=0x01 -> parity bit 1; frame = 0,1,0,0,0,0,0,0,0,1,1.
REQ-025 SHALL cover: TX_PARITY_EN undefined, i_data=0xFF -> 0,1,1,1,1,1,1,1,1,1 (10 ticks); state never equals 10.
REQ-026 SHALL cover: tx_start held high throughout frame with i_data changed to 0x00 mid-frame -> transmitted bits still match original 0xA5; exactly one frame per acceptance; tx_start coincident with STOP-ending tick ignored, next cycle accepted.
REQ-027 SHALL cover: tx_start and baud_tick in same cycle -> state stays IDLE until next baud_tick, start bit exactly one baud period wide.
REQ-028 SHALL cover: reset asserted during DATA_BIT_3 -> same-instant serial_out=1, state=0, tx_busy=0, tx_done=0; no tx_done after release.
